muldiv_sequencer: RTL and testbench

//  Iterative signed multiply/divide unit for the EX stage. It runs MULT (ALU_Control 4'b0101) and DIV (4'b1011)

---
 rtl/muldiv_sequencer_if.sv | 27 ++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives the request side (master); the sequencer drives status and HI/LO (slave).
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cancel;
    logic             Stall;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, ALU_Control, A, B, Cancel,
        input  Stall, Busy, Done, DivByZero, HI, LO
    );

    modport slave (
        input  Start, ALU_Control, A, B, Cancel,
        output Stall, Busy, Done, DivByZero, HI, LO
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV unit: WIDTH shift-add or restoring shift-subtract steps
// on operand magnitudes, then a sign correction as the result is written to HI/LO.
module muldiv_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MUL_CODE = 4'b0101,
    parameter logic [3:0] DIV_CODE = 4'b1011
) (
    input logic               Clk,
    input logic               Reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, abs_a, abs_b;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_next, lo_next;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [CW-1:0]      count;
    logic               neg_res, sign_a, dbz;
    logic               is_mul, is_div, b_zero;

    assign is_mul = (bus.ALU_Control == MUL_CODE);
    assign is_div = (bus.ALU_Control == DIV_CODE);
    assign b_zero = (bus.B == '0);
    // Negation as unsigned W bits: the most negative value maps to 2^(W-1) without overflow.
    assign abs_a  = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign abs_b  = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

    // One iteration step: MUL keeps {partial product, remaining multiplier bits},
    // DIV keeps {partial remainder, dividend bits shifted into quotient bits}.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, mag_b};
        acc_step = acc;
        if (state == MUL) begin
            acc_step = {sum, acc[WIDTH-1:1]};
        end else if (diff[WIDTH] == 1'b0) begin
            acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign-corrected result taken from the final step, written on the edge entering DONE.
    always_comb begin
        prod    = neg_res ? (~acc_step + 1'b1) : acc_step;
        hi_next = prod[2*WIDTH-1:WIDTH];
        lo_next = prod[WIDTH-1:0];
        if (state == DIV) begin
            lo_next = neg_res ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
            hi_next = sign_a ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1) : acc_step[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next    = state;
        bus.Stall     = 1'b0;
        bus.Busy      = (state != IDLE);
        bus.Done      = 1'b0;
        bus.DivByZero = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start && is_mul) begin
                    state_next = MUL;
                    bus.Stall  = 1'b1;
                end else if (bus.Start && is_div) begin
                    state_next = b_zero ? DONE : DIV;
                    bus.Stall  = 1'b1;
                end
            end
            MUL, DIV: begin
                bus.Stall = 1'b1;
                if (bus.Cancel) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.Done      = 1'b1;
                bus.DivByZero = dbz;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at E0, per-cycle iteration, and HI/LO update.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            sign_a  <= 1'b0;
            dbz     <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start && (is_mul || (is_div && !b_zero))) begin
                        acc     <= is_mul ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        neg_res <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        sign_a  <= bus.A[WIDTH-1];
                        count   <= CW'(WIDTH - 1);
                        dbz     <= 1'b0;
                    end else if (bus.Start && is_div) begin
                        hi_q <= bus.A;
                        lo_q <= '1;
                        dbz  <= 1'b1;
                    end
                end
                MUL, DIV: begin
                    if (!bus.Cancel) begin
                        acc   <= acc_step;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            hi_q <= hi_next;
                            lo_q <= lo_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.HI = hi_q;
    assign bus.LO = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, divide-by-zero,
// cancel, async reset, foreign codes and back-to-back operation.
module tb_muldiv_sequencer;
    localparam logic [3:0] MULC = 4'b0101;
    localparam logic [3:0] DIVC = 4'b1011;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    muldiv_sequencer_if #(.WIDTH(32)) ifc ();

    muldiv_sequencer #(
        .WIDTH   (32),
        .MUL_CODE(MULC),
        .DIV_CODE(DIVC)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns #1 after the edge ending Done.
    task automatic do_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz, input int exp_lat);
        int   stalls;
        int   done_at;
        logic dbz_seen;
        logic [31:0] hi_seen, lo_seen;
        stalls   = 0;
        done_at  = -1;
        dbz_seen = 1'b0;
        hi_seen  = '0;
        lo_seen  = '0;
        ifc.Start       = 1'b1;
        ifc.ALU_Control = code;
        ifc.A           = a;
        ifc.B           = b;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            @(negedge clk);
            if (ifc.Stall) stalls++;
            if (ifc.Done) begin
                done_at  = c;
                dbz_seen = ifc.DivByZero;
                hi_seen  = ifc.HI;
                lo_seen  = ifc.LO;
            end
            @(posedge clk);
            #1;
            ifc.Start       = 1'b0;
            ifc.ALU_Control = 4'($urandom);
            ifc.A           = $urandom;
            ifc.B           = $urandom;
        end
        check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_lat));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
        check({tag, "_dbz"}, 64'(dbz_seen), 64'(exp_dbz));
        check({tag, "_hi"}, 64'(hi_seen), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_seen), 64'(exp_lo));
        check({tag, "_hold"}, {ifc.HI, ifc.LO}, {exp_hi, exp_lo});
        check({tag, "_idle"}, 64'(ifc.Busy), 64'd0);
    endtask

    initial begin
        int   ndone;
        logic seen;
        n_vec           = 0;
        n_err           = 0;
        rst             = 1'b1;
        ifc.Start       = 1'b0;
        ifc.ALU_Control = 4'b0000;
        ifc.A           = '0;
        ifc.B           = '0;
        ifc.Cancel      = 1'b0;
        #12;
        check("reset_flags", {60'd0, ifc.Stall, ifc.Busy, ifc.Done, ifc.DivByZero}, 64'd0);
        check("reset_hilo", {ifc.HI, ifc.LO}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_op("mul_7_m3", MULC, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
        do_op("mul_min_min", MULC, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
        do_op("mul_m5_m6", MULC, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0, 32'h0000001E, 1'b0, 33);
        do_op("mul_wide", MULC, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33);
        do_op("div_m7_2", DIVC, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        do_op("div_min_m1", DIVC, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
        do_op("div_100_m7", DIVC, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 33);
        do_op("div_5_0", DIVC, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);

        // Seed, then cancel a DIV mid-flight.
        do_op("seed", MULC, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);
        ndone           = 0;
        ifc.Start       = 1'b1;
        ifc.ALU_Control = DIVC;
        ifc.A           = 32'd100;
        ifc.B           = 32'd7;
        for (int c = 0; c < 40; c++) begin
            ifc.Cancel = (c == 10);
            if (c >= 1) ifc.Start = 1'b0;
            @(negedge clk);
            if (ifc.Done) ndone++;
            if (c == 10) check("cancel_busy_before", 64'(ifc.Busy), 64'd1);
            if (c == 11) begin
                check("cancel_busy_after", 64'(ifc.Busy), 64'd0);
                check("cancel_stall_after", 64'(ifc.Stall), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        ifc.Cancel = 1'b0;
        check("cancel_no_done", 64'(ndone), 64'd0);
        check("cancel_hilo_kept", {ifc.HI, ifc.LO}, {32'd0, 32'd12});

        // Asynchronous reset in the middle of a MUL.
        ifc.Start       = 1'b1;
        ifc.ALU_Control = MULC;
        ifc.A           = 32'h1234;
        ifc.B           = 32'h5678;
        @(posedge clk);
        #1 ifc.Start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_busy_before", 64'(ifc.Busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", {60'd0, ifc.Stall, ifc.Busy, ifc.Done, ifc.DivByZero}, 64'd0);
        check("rst_mid_hilo", {ifc.HI, ifc.LO}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Codes owned by the single-cycle ALU are ignored.
        ifc.Start       = 1'b1;
        ifc.ALU_Control = 4'b0010;
        ifc.A           = 32'd9;
        ifc.B           = 32'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("foreign_code_quiet", {62'd0, ifc.Stall, ifc.Busy}, 64'd0);
            @(posedge clk);
            #1;
        end

        // Back-to-back MULTs with Start held high.
        ifc.ALU_Control = MULC;
        ifc.A           = 32'd2;
        ifc.B           = 32'd3;
        seen            = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (ifc.Done) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("b2b_first_done", 64'(seen), 64'd1);
        check("b2b_done_stall", 64'(ifc.Stall), 64'd0);
        check("b2b_first_lo", 64'(ifc.LO), 64'd6);
        @(posedge clk);
        #1;
        ifc.A = 32'd4;
        ifc.B = 32'd5;
        @(negedge clk);
        check("b2b_accept_stall", 64'(ifc.Stall), 64'd1);
        check("b2b_accept_idle", 64'(ifc.Busy), 64'd0);
        @(posedge clk);
        #1 ifc.Start = 1'b0;
        ndone = -1;
        for (int c = 1; c < 60 && ndone < 0; c++) begin
            @(negedge clk);
            if (ifc.Done) ndone = c;
            @(posedge clk);
            #1;
        end
        check("b2b_second_latency", 64'(ndone), 64'd33);
        check("b2b_second_hilo", {ifc.HI, ifc.LO}, {32'd0, 32'd20});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
